// File: rtl/sayeh_fetch_unit.sv
// SAYEH PC register and instruction-fetch stage: holds the PC loaded from the address
// logic and runs a read with instruction memory to fill the instruction register.
module sayeh_fetch_unit #(
   parameter logic [15:0] PC_RESET = 16'h0000,
   parameter int unsigned TIMEOUT  = 15,
   parameter logic [15:0] NOP_WORD = 16'h0000
) (
   input  logic        clk,
   input  logic        ExternalReset,
   input  logic [15:0] ALout,
   input  logic        EnablePC,
   input  logic        FetchReq,
   input  logic        MemReady,
   input  logic [15:0] MemData,
   output logic [15:0] PCout,
   output logic [15:0] MemAddr,
   output logic        MemReadReq,
   output logic [15:0] IRout,
   output logic        FetchDone,
   output logic        Busy,
   output logic        BusError,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   logic [1:0] state;
   logic [7:0] wait_cnt;
   logic       done_pend;

   // Memory handshake: MemReadReq rises with MemAddr valid and both stay stable until
   // the cycle MemReady is seen high (word taken from MemData) or the wait budget runs out.
   always_ff @(posedge clk or posedge ExternalReset) begin
      if (ExternalReset) begin
         state      <= IDLE;
         wait_cnt   <= 8'd0;
         done_pend  <= 1'b0;
         PCout      <= PC_RESET;
         MemAddr    <= 16'h0000;
         MemReadReq <= 1'b0;
         IRout      <= 16'h0000;
         FetchDone  <= 1'b0;
         BusError   <= 1'b0;
      end else begin
         FetchDone <= 1'b0;
         BusError  <= 1'b0;
         case (state)
            IDLE: begin
               if (EnablePC) PCout <= ALout;
               if (FetchReq) begin
                  MemAddr    <= EnablePC ? ALout : PCout;
                  MemReadReq <= 1'b1;
                  wait_cnt   <= 8'd0;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (MemReady) begin
                  IRout      <= MemData;
                  MemReadReq <= 1'b0;
                  FetchDone  <= 1'b1;
                  state      <= DONE;
               end else if (wait_cnt == LAST_WAIT) begin
                  // Timeout: the error pulse leads, FetchDone follows one cycle later.
                  IRout      <= NOP_WORD;
                  MemReadReq <= 1'b0;
                  BusError   <= 1'b1;
                  done_pend  <= 1'b1;
                  state      <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            DONE: begin
               if (done_pend) begin
                  FetchDone <= 1'b1;
                  done_pend <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_sayeh_fetch_unit.sv
// Directed and randomized bench for sayeh_fetch_unit with a transaction-level model
// of PC, IR and fetch timing.
module tb_sayeh_fetch_unit;

   localparam int          T   = 4;
   localparam logic [15:0] NOP = 16'hDEAD;

   logic        clk;
   logic        ExternalReset;
   logic [15:0] ALout;
   logic        EnablePC;
   logic        FetchReq;
   logic        MemReady;
   logic [15:0] MemData;
   logic [15:0] PCout;
   logic [15:0] MemAddr;
   logic        MemReadReq;
   logic [15:0] IRout;
   logic        FetchDone;
   logic        Busy;
   logic        BusError;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   logic [15:0] m_pc;
   logic [15:0] m_ir;
   logic [15:0] exp_q[$];

   sayeh_fetch_unit #(.PC_RESET(16'h0000), .TIMEOUT(T), .NOP_WORD(NOP)) dut (
      .clk(clk), .ExternalReset(ExternalReset), .ALout(ALout), .EnablePC(EnablePC),
      .FetchReq(FetchReq), .MemReady(MemReady), .MemData(MemData), .PCout(PCout),
      .MemAddr(MemAddr), .MemReadReq(MemReadReq), .IRout(IRout), .FetchDone(FetchDone),
      .Busy(Busy), .BusError(BusError), .dbg_state(dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      EnablePC = 1'b0;
      FetchReq = 1'b0;
      MemReady = 1'b0;
   endtask

   // PC load in IDLE; a stray MemReady here must not touch IR.
   task automatic load_pc(input logic [15:0] al);
      EnablePC = 1'b1;
      ALout    = al;
      FetchReq = 1'b0;
      MemReady = 1'b1;
      MemData  = 16'($urandom);
      @(negedge clk);
      m_pc = al;
      chk("load_pc", PCout, m_pc);
      chk("load_ir_kept", IRout, m_ir);
      chk("load_busy", 16'(Busy), 16'd0);
      idle_inputs();
   endtask

   // One fetch transaction; d = WAIT cycle index at which memory answers.
   task automatic do_fetch(input logic en, input logic [15:0] al, input int d,
                           input logic [15:0] data, input logic freeze);
      logic [15:0] addr;
      int exp_done, exp_be, wait_cycles, fd_cnt, be_cnt;
      addr = en ? al : m_pc;
      if (en) m_pc = al;
      if (d < T) begin
         exp_q.push_back(data);
         exp_done = d + 2; exp_be = -1; wait_cycles = d + 1;
      end else begin
         exp_q.push_back(NOP);
         exp_done = T + 2; exp_be = T + 1; wait_cycles = T;
      end
      fd_cnt = 0; be_cnt = 0;
      EnablePC = en;
      ALout    = al;
      FetchReq = 1'b1;
      MemReady = 1'b0;
      MemData  = 16'($urandom);
      for (int c = 1; c <= exp_done + 1; c++) begin
         @(negedge clk);
         if (FetchDone) fd_cnt++;
         if (BusError) be_cnt++;
         if (c <= wait_cycles) begin
            chk("wait_addr", MemAddr, addr);
            chk("wait_req", 16'(MemReadReq), 16'd1);
            chk("wait_busy", 16'(Busy), 16'd1);
            chk("wait_pc", PCout, m_pc);
         end
         if (c == exp_be) chk("buserr_at", 16'(BusError), 16'd1);
         if (c == exp_done) begin
            chk("done_at", 16'(FetchDone), 16'd1);
            chk("done_ir", IRout, exp_q[0]);
            chk("done_req", 16'(MemReadReq), 16'd0);
         end
         FetchReq = 1'b0;
         EnablePC = freeze && (c <= wait_cycles);
         ALout    = freeze ? 16'h9999 : 16'($urandom);
         MemReady = (c == d + 1);
         MemData  = (c == d + 1) ? data : 16'($urandom);
      end
      m_ir = exp_q.pop_front();
      chk("end_busy", 16'(Busy), 16'd0);
      chk("end_done_cnt", 16'(fd_cnt), 16'd1);
      chk("end_be_cnt", 16'(be_cnt), (exp_be > 0) ? 16'd1 : 16'd0);
      chk("end_pc", PCout, m_pc);
      chk("end_ir", IRout, m_ir);
      idle_inputs();
   endtask

   initial begin
      ExternalReset = 1'b1;
      ALout = 16'h0; MemData = 16'h0;
      idle_inputs();
      @(negedge clk);
      chk("rst_pc", PCout, 16'h0000);
      chk("rst_ir", IRout, 16'h0000);
      chk("rst_addr", MemAddr, 16'h0000);
      chk("rst_req", 16'(MemReadReq), 16'd0);
      chk("rst_busy", 16'(Busy), 16'd0);
      chk("rst_flags", {14'd0, FetchDone, BusError}, 16'd0);
      ExternalReset = 1'b0;
      m_pc = 16'h0000; m_ir = 16'h0000;
      @(negedge clk);

      // basic fetch, memory answers on the second WAIT cycle
      load_pc(16'h0040);
      do_fetch(1'b0, 16'h0000, 1, 16'h1234, 1'b0);
      // load and fetch together
      do_fetch(1'b1, 16'h00A5, 0, 16'h5A5A, 1'b0);
      // PC frozen while fetching, loadable afterwards
      do_fetch(1'b0, 16'h0000, 2, 16'hC0DE, 1'b1);
      load_pc(16'h9999);
      // timeout with no answer, then answer on the last allowed cycle
      do_fetch(1'b0, 16'h0000, 99, 16'h1111, 1'b0);
      do_fetch(1'b0, 16'h0000, T - 1, 16'hBEEF, 1'b0);

      // back-to-back across the address wrap with FetchReq held high
      EnablePC = 1'b1; ALout = 16'hFFFF; FetchReq = 1'b1;
      @(negedge clk);
      chk("b2b_addr0", MemAddr, 16'hFFFF);
      EnablePC = 1'b0; MemReady = 1'b1; MemData = 16'hA1A1;
      @(negedge clk);
      chk("b2b_done0", 16'(FetchDone), 16'd1);
      chk("b2b_ir0", IRout, 16'hA1A1);
      MemReady = 1'b0; EnablePC = 1'b1; ALout = 16'h0000;
      @(negedge clk);
      chk("b2b_gap_pc", PCout, 16'hFFFF);
      chk("b2b_gap_done", 16'(FetchDone), 16'd0);
      chk("b2b_gap_busy", 16'(Busy), 16'd0);
      @(negedge clk);
      chk("b2b_addr1", MemAddr, 16'h0000);
      chk("b2b_pc1", PCout, 16'h0000);
      FetchReq = 1'b0; EnablePC = 1'b0; MemReady = 1'b1; MemData = 16'hB2B2;
      @(negedge clk);
      chk("b2b_done1", 16'(FetchDone), 16'd1);
      chk("b2b_ir1", IRout, 16'hB2B2);
      idle_inputs();
      @(negedge clk);
      m_pc = 16'h0000; m_ir = 16'hB2B2;

      // asynchronous reset in the middle of a fetch
      load_pc(16'h0040);
      FetchReq = 1'b1;
      @(negedge clk);
      FetchReq = 1'b0;
      chk("mid_req", 16'(MemReadReq), 16'd1);
      #2 ExternalReset = 1'b1;
      #1;
      chk("arst_pc", PCout, 16'h0000);
      chk("arst_req", 16'(MemReadReq), 16'd0);
      chk("arst_busy", 16'(Busy), 16'd0);
      chk("arst_ir", IRout, 16'h0000);
      chk("arst_addr", MemAddr, 16'h0000);
      @(negedge clk);
      ExternalReset = 1'b0;
      m_pc = 16'h0000; m_ir = 16'h0000;
      @(negedge clk);
      chk("post_rst_busy", 16'(Busy), 16'd0);
      chk("post_rst_req", 16'(MemReadReq), 16'd0);

      // randomized transactions
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) load_pc(16'($urandom));
         do_fetch(1'($urandom), 16'($urandom), int'($urandom_range(0, T + 2)),
                  16'($urandom), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sayeh_fetch_unit.md
Name: sayeh_fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly downstream of the address logic.
- Registers the 16-bit next-address value driven by the address logic into the PC.
- On controller request, runs a read handshake with instruction memory and latches the returned word into the instruction register.
- Exposes PC to the address logic (PCside) and IR to the decoder; a memory timeout guard flags a dead bus.

Parameters:
- PC_RESET, 16'h0000, PC value after reset.
- TIMEOUT, 15, maximum WAIT cycles before bus error; legal range 1..255.
- NOP_WORD, 16'h0000, value loaded into IR on timeout.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- ExternalReset  input  1  asynchronous, active-high reset.
- ALout  input  16  next-PC value from the address logic.
- EnablePC  input  1  load PC from ALout this cycle.
- FetchReq  input  1  level request from the controller to fetch at the current PC.
- MemReady  input  1  memory has valid data on MemData.
- MemData  input  16  instruction word from memory.
- PCout  output  16  current PC (to PCside of the address logic).
- MemAddr  output  16  fetch address, held stable while MemReadReq=1.
- MemReadReq  output  1  read request to memory.
- IRout  output  16  instruction register.
- FetchDone  output  1  one-cycle pulse when IRout has been updated.
- Busy  output  1  high in any state other than IDLE.
- BusError  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - PCout=PC_RESET; IRout=16'h0000; MemAddr=16'h0000.
  - MemReadReq=0, FetchDone=0, BusError=0, Busy=0.
  - State=IDLE; wait counter=0.
- State machine: IDLE, WAIT, DONE.
- IDLE:
  - If EnablePC=1, PC<=ALout.
  - If FetchReq=1, MemAddr<=(EnablePC ? ALout : PC) and MemReadReq<=1; counter<=0; go to WAIT.
  - When EnablePC and FetchReq are both high, the PC update and the fetch start occur in the same cycle, and the fetch uses the new address.
- WAIT:
  - MemReadReq=1, MemAddr held, Busy=1.
  - EnablePC is ignored; PC is frozen during a fetch.
  - If MemReady=1: IR<=MemData, MemReadReq<=0, go to DONE. This applies even on the same cycle the counter reaches TIMEOUT; data wins.
  - Else if counter==TIMEOUT-1: IR<=NOP_WORD, BusError<=1 for one cycle, MemReadReq<=0, go to DONE.
  - Else counter<=counter+1.
- DONE:
  - FetchDone=1 for exactly one cycle, then return to IDLE.
  - FetchReq is not sampled in DONE; a FetchReq still high starts a new fetch on the following IDLE cycle.
  - Minimum request-to-request spacing is therefore 3 cycles.
- Latency:
  - FetchReq sampled in cycle N with MemReady on the first WAIT cycle (N+1): IRout valid and FetchDone=1 in cycle N+2.
  - Timeout: BusError and FetchDone are asserted on successive cycles, TIMEOUT+1 and TIMEOUT+2 cycles after FetchReq is sampled.
- Arithmetic: PC is a plain 16-bit register with no internal increment; sequencing comes from the address logic. ALout=16'hFFFF then PC+1 arriving as 16'h0000 is a normal load, not an error.
- MemReady outside WAIT is ignored. MemData is sampled only when MemReady=1 in WAIT.
- Outputs are registered. The only combinational path is Busy, which is decoded from state.

Test Plan:
- Reset: assert ExternalReset mid-WAIT, asynchronously and off-edge -> outputs return to reset values immediately, with PCout=0000 and MemReadReq=0; after deassert, state is IDLE.
- Basic fetch:
  - Stimulus: EnablePC=1, ALout=0x0040, then FetchReq=1; MemReady raised 2 cycles later with MemData=0x1234.
  - Required: MemAddr=0x0040 throughout WAIT, IRout=0x1234, FetchDone pulses once, PCout=0x0040.
- Simultaneous load and fetch:
  - Stimulus: EnablePC=1 and FetchReq=1 in the same cycle with ALout=0x00A5.
  - Required: PCout=0x00A5 and MemAddr=0x00A5.
- PC freeze: EnablePC=1 with ALout=0x9999 during WAIT -> PCout unchanged; after DONE, EnablePC loads 0x9999.
- Timeout:
  - Stimulus: TIMEOUT=4, MemReady held low.
  - Required: BusError pulses 5 cycles after FetchReq is sampled, then FetchDone; IRout=NOP_WORD; MemReadReq low afterwards.
  - Corner: MemReady rises exactly on the timeout cycle -> data is captured and BusError stays 0.
- Wrap and back-to-back:
  - Stimulus: ALout=0xFFFF then 0x0000, with FetchReq held high.
  - Required: consecutive fetches from 0xFFFF then 0x0000, FetchDone spaced exactly 3 cycles apart when MemReady arrives in the first WAIT cycle.
